// File: rtl/uart_pkg.sv
// Shared UART definitions: ASCII constants and packetizer state encoding.
package uart_pkg;

  localparam logic [7:0] ASCII_0     = 8'h30;
  localparam logic [7:0] ASCII_A_OFS = 8'h37;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT,
    FIN
  } pkt_state_t;

endpackage

// File: rtl/uart_hex_packetizer_nibble_to_ascii.sv
// Combinational 4-bit value to uppercase ASCII hex digit converter.
module nibble_to_ascii
  import uart_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [7:0] ascii
);

  // 0-9 map onto '0'..'9', 10-15 onto 'A'..'F'
  always_comb begin
    if (nibble < 4'd10) ascii = ASCII_0 + {4'h0, nibble};
    else                ascii = ASCII_A_OFS + {4'h0, nibble};
  end

endmodule

// File: rtl/uart_hex_packetizer.sv
// Formats one word as uppercase ASCII hex (MSB nibble first) plus a line
// terminator and feeds it byte by byte to a UART transmitter.
// Optional macro UART_PKT_CRLF_EN: terminator is CR LF instead of LF alone.
module uart_hex_packetizer
  import uart_pkg::*;
#(
  parameter int unsigned WORD_W = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [WORD_W-1:0] DATA_IN,
  input  logic              DATA_VALID,
  output logic              DATA_READY,
  output logic [7:0]        TX_DATA,
  output logic              TX_START,
  input  logic              TX_DONE,
  output logic              BUSY,
  output logic              FRAME_DONE
);

  localparam int unsigned NIBBLES = WORD_W / 4;
`ifdef UART_PKT_CRLF_EN
  localparam int unsigned FRAME_LEN = NIBBLES + 2;
`else
  localparam int unsigned FRAME_LEN = NIBBLES + 1;
`endif
  localparam int unsigned IDX_W = $clog2(NIBBLES + 2);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  pkt_state_t        state_q, state_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              tx_start_q, tx_start_d;
  logic              busy_q, busy_d;
  logic              ready_q, ready_d;
  logic              frame_done_q, frame_done_d;

  logic [WORD_W-1:0] src_word;
  logic [IDX_W-1:0]  char_idx;
  logic [3:0]        nibble;
  logic [7:0]        hex_char;
  logic [7:0]        next_char;

  // The byte loaded on each TX_START is the one about to be sent: the first
  // character comes straight from DATA_IN at accept, later ones from the
  // latched word at index+1, so TX_DATA is registered alongside TX_START.
  always_comb begin
    src_word = (state_q == IDLE) ? DATA_IN : word_q;
    char_idx = (state_q == IDLE) ? '0 : idx_q + IDX_W'(1);
  end

  // Pick the nibble addressed by char_idx, MSB nibble at index 0
  always_comb begin
    nibble = '0;
    for (int unsigned i = 0; i < NIBBLES; i++) begin
      if (char_idx == IDX_W'(NIBBLES - 1 - i)) nibble = src_word[i*4 +: 4];
    end
  end

  nibble_to_ascii u_hex (
    .nibble (nibble),
    .ascii  (hex_char)
  );

  // Hex digits first, then the line terminator
  always_comb begin
    if (char_idx < IDX_W'(NIBBLES)) next_char = hex_char;
`ifdef UART_PKT_CRLF_EN
    else if (char_idx == IDX_W'(NIBBLES)) next_char = ASCII_CR;
`endif
    else next_char = ASCII_LF;
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d      = state_q;
    word_d       = word_q;
    idx_d        = idx_q;
    tx_data_d    = tx_data_q;
    tx_start_d   = 1'b0;
    busy_d       = busy_q;
    ready_d      = ready_q;
    frame_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (DATA_VALID && ready_q) begin
          word_d     = DATA_IN;
          idx_d      = '0;
          tx_data_d  = next_char;
          tx_start_d = 1'b1;
          busy_d     = 1'b1;
          ready_d    = 1'b0;
          state_d    = SEND;
        end
      end
      SEND: state_d = WAIT;
      WAIT: begin
        if (TX_DONE) begin
          if (idx_q != LAST_IDX) begin
            idx_d      = idx_q + IDX_W'(1);
            tx_data_d  = next_char;
            tx_start_d = 1'b1;
            state_d    = SEND;
          end else begin
            frame_done_d = 1'b1;
            state_d      = FIN;
          end
        end
      end
      FIN: begin
        busy_d  = 1'b0;
        ready_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= IDLE;
      word_q       <= '0;
      idx_q        <= '0;
      tx_data_q    <= '0;
      tx_start_q   <= 1'b0;
      busy_q       <= 1'b0;
      ready_q      <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      word_q       <= word_d;
      idx_q        <= idx_d;
      tx_data_q    <= tx_data_d;
      tx_start_q   <= tx_start_d;
      busy_q       <= busy_d;
      ready_q      <= ready_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign DATA_READY = ready_q;
  assign TX_DATA    = tx_data_q;
  assign TX_START   = tx_start_q;
  assign BUSY       = busy_q;
  assign FRAME_DONE = frame_done_q;

endmodule

// File: tb/tb_uart_hex_packetizer.sv
// Directed bench for uart_hex_packetizer with a 20-cycle transmitter model.
module tb_uart_hex_packetizer;

`ifdef UART_PKT_CRLF_EN
  localparam int FLEN = 10;
`else
  localparam int FLEN = 9;
`endif

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [31:0] DATA_IN = '0;
  logic        DATA_VALID = 1'b0;
  logic        DATA_READY;
  logic [7:0]  TX_DATA;
  logic        TX_START;
  logic        TX_DONE;
  logic        BUSY;
  logic        FRAME_DONE;

  logic        model_done = 1'b0;
  logic        spur = 1'b0;
  assign TX_DONE = model_done | spur;

  uart_hex_packetizer #(.WORD_W(32)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .DATA_IN    (DATA_IN),
    .DATA_VALID (DATA_VALID),
    .DATA_READY (DATA_READY),
    .TX_DATA    (TX_DATA),
    .TX_START   (TX_START),
    .TX_DONE    (TX_DONE),
    .BUSY       (BUSY),
    .FRAME_DONE (FRAME_DONE)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Transmitter model and monitor, sampled on the falling edge
  logic [7:0] byte_q[$];
  int starts = 0, dones = 0, fds = 0;
  int last_done_cyc = 0, fd_cyc = 0, last_start_cyc = 0;
  int hold_err = 0, rdy_err = 0;
  int cnt = 0;
  logic in_byte = 1'b0;
  logic [7:0] held = '0;

  always @(negedge CLK) begin
    if (RST) begin
      cnt = 0;
      model_done = 1'b0;
      in_byte = 1'b0;
    end else begin
      model_done = 1'b0;
      if (cnt > 0) begin
        cnt = cnt - 1;
        if (cnt == 0) model_done = 1'b1;
      end
      if (model_done) begin
        dones = dones + 1;
        last_done_cyc = cyc;
      end
      if (in_byte && !TX_START && TX_DATA !== held) hold_err = hold_err + 1;
      if (model_done || spur) in_byte = 1'b0;
      if (TX_START) begin
        starts = starts + 1;
        last_start_cyc = cyc;
        byte_q.push_back(TX_DATA);
        cnt = 20;
        in_byte = 1'b1;
        held = TX_DATA;
      end
      if (FRAME_DONE) begin
        fds = fds + 1;
        fd_cyc = cyc;
      end
      if (BUSY && DATA_READY) rdy_err = rdy_err + 1;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge CLK);
    #1;
  endtask

  function automatic logic [7:0] exp_char(input logic [31:0] w, input int p);
    int v;
    if (p < 8) begin
      v = int'(w[(7-p)*4 +: 4]);
      return (v < 10) ? 8'(48 + v) : 8'(65 + v - 10);
    end
`ifdef UART_PKT_CRLF_EN
    if (p == 8) return 8'h0D;
`endif
    return 8'h0A;
  endfunction

  task automatic wait_fd(input int maxc);
    int t;
    t = fds + 1;
    for (int i = 0; i < maxc; i++) begin
      tick();
      if (fds >= t) break;
    end
    chk("frame_done_seen", 32'(fds >= t), 32'd1);
  endtask

  task automatic check_frame(input string tag, input logic [31:0] w, input int base);
    chk({tag, "_count"}, 32'(byte_q.size() - base >= FLEN), 32'd1);
    for (int p = 0; p < FLEN; p++) begin
      if (base + p < byte_q.size())
        chk($sformatf("%s_b%0d", tag, p), 32'(byte_q[base+p]), 32'(exp_char(w, p)));
    end
  endtask

  task automatic send_word(input string tag, input logic [31:0] w);
    DATA_IN = w;
    DATA_VALID = 1'b1;
    tick();
    chk({tag, "_first_start"}, 32'(TX_START), 32'd1);
    chk({tag, "_first_char"}, 32'(TX_DATA), 32'(exp_char(w, 0)));
    chk({tag, "_busy"}, 32'(BUSY), 32'd1);
    chk({tag, "_ready_low"}, 32'(DATA_READY), 32'd0);
    DATA_VALID = 1'b0;
  endtask

  initial begin
    int base, s0, f0, d0, f1;

    // Reset state
    RST = 1'b1;
    repeat (3) tick();
    chk("rst_ready", 32'(DATA_READY), 32'd1);
    chk("rst_txdata", 32'(TX_DATA), 32'h00);
    chk("rst_start", 32'(TX_START), 32'd0);
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_fd", 32'(FRAME_DONE), 32'd0);
    RST = 1'b0;
    tick();

    // Mixed digits and letters
    base = byte_q.size(); s0 = starts;
    send_word("w1234", 32'h1234ABCD);
    wait_fd(400);
    chk("w1234_fd_latency", 32'(fd_cyc - last_done_cyc), 32'd1);
    chk("w1234_starts", 32'(starts - s0), 32'(FLEN));
    check_frame("w1234", 32'h1234ABCD, base);
    tick();
    chk("w1234_ready_after", 32'(DATA_READY), 32'd1);
    chk("w1234_busy_after", 32'(BUSY), 32'd0);
    chk("w1234_txdata_kept", 32'(TX_DATA), 32'h0A);
    chk("w1234_fd_single", 32'(FRAME_DONE), 32'd0);

    // All zeros
    base = byte_q.size(); s0 = starts;
    send_word("w0000", 32'h00000000);
    wait_fd(400);
    chk("w0000_starts", 32'(starts - s0), 32'(FLEN));
    check_frame("w0000", 32'h00000000, base);
    tick();

    // All F with a competing request during the frame
    base = byte_q.size(); s0 = starts;
    send_word("wffff", 32'hFFFFFFFF);
    repeat (5) tick();
    DATA_IN = 32'h11111111;
    DATA_VALID = 1'b1;
    f0 = fds + 1;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (fds >= f0) break;
    end
    DATA_VALID = 1'b0;
    chk("wffff_fd_seen", 32'(fds >= f0), 32'd1);
    repeat (30) tick();
    chk("wffff_starts", 32'(starts - s0), 32'(FLEN));
    chk("wffff_ready_while_busy", 32'(rdy_err), 32'd0);
    chk("wffff_busy_after", 32'(BUSY), 32'd0);
    check_frame("wffff", 32'hFFFFFFFF, base);

    // Reset one cycle after the 3rd TX_DONE
    s0 = starts; f0 = fds; d0 = dones;
    send_word("wrst", 32'h9ABC5678);
    for (int i = 0; i < 200; i++) begin
      if (dones >= d0 + 3) break;
      tick();
    end
    chk("wrst_three_dones", 32'(dones - d0), 32'd3);
    tick();
    chk("wrst_fourth_start", 32'(TX_START), 32'd1);
    RST = 1'b1;
    tick();
    chk("wrst_txdata", 32'(TX_DATA), 32'h00);
    chk("wrst_busy", 32'(BUSY), 32'd0);
    chk("wrst_ready", 32'(DATA_READY), 32'd1);
    chk("wrst_start", 32'(TX_START), 32'd0);
    RST = 1'b0;
    repeat (60) tick();
    chk("wrst_no_more_starts", 32'(starts - s0), 32'd4);
    chk("wrst_no_fd", 32'(fds - f0), 32'd0);

    // Spurious TX_DONE in IDLE and during SEND
    s0 = starts;
    spur = 1'b1;
    tick();
    spur = 1'b0;
    tick();
    chk("spur_idle_busy", 32'(BUSY), 32'd0);
    chk("spur_idle_starts", 32'(starts - s0), 32'd0);
    base = byte_q.size();
    send_word("wspur", 32'h5A5A5A5A);
    spur = 1'b1;
    tick();
    spur = 1'b0;
    chk("spur_send_no_restart", 32'(TX_START), 32'd0);
    chk("spur_send_hold", 32'(TX_DATA), 32'h35);
    wait_fd(400);
    chk("wspur_starts", 32'(starts - s0), 32'(FLEN));
    check_frame("wspur", 32'h5A5A5A5A, base);
    tick();

    // DATA_VALID held high: back-to-back frames
    base = byte_q.size(); s0 = starts;
    DATA_IN = 32'hDEADBEEF;
    DATA_VALID = 1'b1;
    tick();
    chk("b2b_first_start", 32'(TX_START), 32'd1);
    wait_fd(400);
    f1 = fd_cyc;
    tick();
    chk("b2b_ready_rise", 32'(DATA_READY), 32'd1);
    tick();
    chk("b2b_second_start", 32'(TX_START), 32'd1);
    chk("b2b_gap", 32'(last_start_cyc - f1), 32'd2);
    DATA_VALID = 1'b0;
    wait_fd(400);
    chk("b2b_starts", 32'(starts - s0), 32'(2 * FLEN));
    check_frame("b2b_f1", 32'hDEADBEEF, base);
    check_frame("b2b_f2", 32'hDEADBEEF, base + FLEN);

    chk("tx_data_hold", 32'(hold_err), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
